// File: rtl/led_shift_driver.sv
// Serial driver for chained 74HC595-style LED shift registers: shift a word out, then pulse the latch.
// Defining LED_DRV_DBUF_EN adds a one-word pending buffer so words can be queued while a transfer runs.
module led_shift_driver #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned LATCH_CYC = 1
) (
    input  logic              i_CLK,
    input  logic              i_RESET,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic              o_LEDClk,
    output logic              o_LEDData,
    output logic              o_LEDLatch_n,
    output logic              o_Busy
);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned LAT_W = $clog2(LATCH_CYC) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DIV_W-1:0]  div_q;
    logic [LAT_W-1:0]  lat_q;
    logic              led_clk_q;
    logic              led_data_q;
    logic              latch_n_q;
    logic              ready_q;
    logic              busy_q;

    logic              accept_c;
    logic              latch_done_c;
    logic              start_c;
    logic [DATA_W-1:0] start_word_c;
    logic              first_bit_c;
    logic              next_bit_c;
    logic [DATA_W-1:0] shreg_shift_c;

`ifdef LED_DRV_DBUF_EN
    logic [DATA_W-1:0] pend_q;
    logic              pend_valid_q;
    logic              pend_load_c;
    logic              pend_valid_d;
`endif

    // Handshake decode and the word/bit that a new transfer starts with.
    always_comb begin
        accept_c     = i_Valid && ready_q;
        latch_done_c = (state_q == S_LATCH) && (lat_q == LAT_LAST);
`ifdef LED_DRV_DBUF_EN
        // A word offered at the end of LATCH with an empty buffer starts directly.
        start_c      = ((state_q == S_IDLE) && accept_c) ||
                       (latch_done_c && (pend_valid_q || accept_c));
        start_word_c = pend_valid_q ? pend_q : i_Data;
        pend_load_c  = accept_c && !(start_c && !pend_valid_q);
        pend_valid_d = pend_load_c || (pend_valid_q && !start_c);
`else
        start_c      = (state_q == S_IDLE) && accept_c;
        start_word_c = i_Data;
`endif
        if (MSB_FIRST != 0) begin
            first_bit_c   = start_word_c[DATA_W-1];
            next_bit_c    = shreg_q[DATA_W-2];
            shreg_shift_c = {shreg_q[DATA_W-2:0], 1'b0};
        end else begin
            first_bit_c   = start_word_c[0];
            next_bit_c    = shreg_q[1];
            shreg_shift_c = {1'b0, shreg_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            lat_q      <= '0;
            led_clk_q  <= 1'b0;
            led_data_q <= 1'b0;
            latch_n_q  <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef LED_DRV_DBUF_EN
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
`endif
        end else begin
            if (start_c) begin
                state_q    <= S_SHIFT;
                shreg_q    <= start_word_c;
                bit_q      <= '0;
                div_q      <= '0;
                led_clk_q  <= 1'b0;
                led_data_q <= first_bit_c;
                latch_n_q  <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    S_SHIFT: begin
                        if (div_q == DIV_LAST) begin
                            div_q     <= '0;
                            led_clk_q <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_q    <= S_LATCH;
                                lat_q      <= '0;
                                led_data_q <= 1'b0;
                                latch_n_q  <= 1'b0;
                            end else begin
                                bit_q      <= bit_q + 1'b1;
                                shreg_q    <= shreg_shift_c;
                                led_data_q <= next_bit_c;
                            end
                        end else begin
                            if (div_q == DIV_RISE) begin
                                led_clk_q <= 1'b1;
                            end
                            div_q <= div_q + 1'b1;
                        end
                    end
                    S_LATCH: begin
                        if (latch_done_c) begin
                            state_q   <= S_IDLE;
                            latch_n_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

`ifdef LED_DRV_DBUF_EN
            pend_valid_q <= pend_valid_d;
            ready_q      <= !pend_valid_d;
            if (pend_load_c) begin
                pend_q <= i_Data;
            end
`else
            if (start_c) begin
                ready_q <= 1'b0;
            end else if (latch_done_c) begin
                ready_q <= 1'b1;
            end
`endif
        end
    end

    assign o_Ready      = ready_q;
    assign o_LEDClk     = led_clk_q;
    assign o_LEDData    = led_data_q;
    assign o_LEDLatch_n = latch_n_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: three parameter sets, directed and random words against a timing model.
module tb_led_shift_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] din;
    logic [2:0]  vld;
    logic [2:0]  rdy, lclk, ldat, llat, bsy;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance parameter sets: 0 = default, 1 = LSB first, 2 = 24-bit fast clock, long latch.
    int cfg_w  [3] = '{16, 16, 24};
    int cfg_cd [3] = '{2, 2, 1};
    int cfg_l  [3] = '{1, 1, 3};
    int cfg_msb[3] = '{1, 0, 1};

`ifdef LED_DRV_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    always #5 clk = ~clk;

    led_shift_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1), .LATCH_CYC(1)) u0 (
        .i_CLK(clk), .i_RESET(rst), .i_Data(din[15:0]), .i_Valid(vld[0]), .o_Ready(rdy[0]),
        .o_LEDClk(lclk[0]), .o_LEDData(ldat[0]), .o_LEDLatch_n(llat[0]), .o_Busy(bsy[0]));
    led_shift_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(0), .LATCH_CYC(1)) u1 (
        .i_CLK(clk), .i_RESET(rst), .i_Data(din[15:0]), .i_Valid(vld[1]), .o_Ready(rdy[1]),
        .o_LEDClk(lclk[1]), .o_LEDData(ldat[1]), .o_LEDLatch_n(llat[1]), .o_Busy(bsy[1]));
    led_shift_driver #(.DATA_W(24), .CLK_DIV(1), .MSB_FIRST(1), .LATCH_CYC(3)) u2 (
        .i_CLK(clk), .i_RESET(rst), .i_Data(din), .i_Valid(vld[2]), .o_Ready(rdy[2]),
        .o_LEDClk(lclk[2]), .o_LEDData(ldat[2]), .o_LEDLatch_n(llat[2]), .o_Busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] wmask(input int s);
        logic [31:0] one = 32'd1;
        return 24'((one << cfg_w[s]) - 32'd1);
    endfunction

    // Outputs expected e cycles after the accept edge, straight from the bit/phase arithmetic.
    task automatic check_edge(input int s, input logic [23:0] word, input int e, input logic rdy_exp);
        int t = 2 * cfg_cd[s] * cfg_w[s];
        int b, idx;
        logic c, d, l, bz;
        if (e < t) begin
            b   = e / (2 * cfg_cd[s]);
            idx = (cfg_msb[s] != 0) ? cfg_w[s] - 1 - b : b;
            d   = word[idx];
            c   = (e % (2 * cfg_cd[s])) >= cfg_cd[s];
            l   = 1'b1;
            bz  = 1'b1;
        end else if (e < t + cfg_l[s]) begin
            c = 1'b0; d = 1'b0; l = 1'b0; bz = 1'b1;
        end else begin
            c = 1'b0; d = 1'b0; l = 1'b1; bz = 1'b0;
        end
        check($sformatf("u%0d e%0d clk", s, e), 32'(lclk[s]), 32'(c));
        check($sformatf("u%0d e%0d data", s, e), 32'(ldat[s]), 32'(d));
        check($sformatf("u%0d e%0d latch_n", s, e), 32'(llat[s]), 32'(l));
        check($sformatf("u%0d e%0d busy", s, e), 32'(bsy[s]), 32'(bz));
        check($sformatf("u%0d e%0d ready", s, e), 32'(rdy[s]), 32'(rdy_exp));
    endtask

    // One full transfer; optionally keep i_Valid high with all-ones data while busy.
    task automatic run_xfer(input int s, input logic [23:0] word, input bit hold_ones);
        int total = 2 * cfg_cd[s] * cfg_w[s] + cfg_l[s];
        int pulses = 0;
        int lows = 0;
        logic prev = 1'b0;
        logic [23:0] cap = '0;
        check($sformatf("u%0d pre_ready", s), 32'(rdy[s]), 32'd1);
        din    = word;
        vld[s] = 1'b1;
        @(posedge clk); #1;
        vld[s] = 1'b0;
        if (hold_ones) begin
            din    = 24'hFFFFFF;
            vld[s] = 1'b1;
        end
        for (int e = 0; e <= total; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            check_edge(s, word, e, (e >= total) ? 1'b1 : DBUF);
            if (lclk[s] && !prev) begin
                if (cfg_msb[s] != 0) cap = {cap[22:0], ldat[s]};
                else if (pulses < 24) cap[pulses] = ldat[s];
                pulses++;
            end
            if (!llat[s]) lows++;
            prev = lclk[s];
        end
        vld[s] = 1'b0;
        check($sformatf("u%0d pulses", s), 32'(pulses), 32'(cfg_w[s]));
        check($sformatf("u%0d shifted_word", s), 32'(cap), 32'(word & wmask(s)));
        check($sformatf("u%0d latch_low_cycles", s), 32'(lows), 32'(cfg_l[s]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] w;
        int s;
        rst = 1'b1;
        vld = '0;
        din = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d rst ready", i), 32'(rdy[i]), 32'd1);
            check($sformatf("u%0d rst clk", i), 32'(lclk[i]), 32'd0);
            check($sformatf("u%0d rst data", i), 32'(ldat[i]), 32'd0);
            check($sformatf("u%0d rst latch_n", i), 32'(llat[i]), 32'd1);
            check($sformatf("u%0d rst busy", i), 32'(bsy[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(0, 24'h00A5C3, 1'b0);
        run_xfer(1, 24'h000001, 1'b0);
        if (!DBUF) run_xfer(0, 24'h003C5A, 1'b1);
        run_xfer(2, 24'h800001, 1'b0);

        // Reset part-way through a transfer: abort immediately, no latch pulse afterwards.
        check("u0 pre_ready_rst", 32'(rdy[0]), 32'd1);
        din = 24'h00F00F; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        for (int e = 0; e < 20; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            check_edge(0, 24'h00F00F, e, DBUF);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid clk", 32'(lclk[0]), 32'd0);
        check("rst_mid latch_n", 32'(llat[0]), 32'd1);
        check("rst_mid ready", 32'(rdy[0]), 32'd1);
        check("rst_mid busy", 32'(bsy[0]), 32'd0);
        check("rst_mid data", 32'(ldat[0]), 32'd0);
        begin
            int lows = 0;
            for (int i = 0; i < 70; i++) begin
                @(posedge clk); #1;
                if (!llat[0] || lclk[0]) lows++;
            end
            check("rst_mid no_activity", 32'(lows), 32'd0);
        end

`ifdef LED_DRV_DBUF_EN
        // Queue a second word while the first shifts; it must start right after the latch.
        din = 24'h001234; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        for (int e = 0; e <= 64; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (e == 5) vld[0] = 1'b0;
            check_edge(0, 24'h001234, e, (e < 5) ? 1'b1 : 1'b0);
            if (e == 4) begin
                din = 24'h005678; vld[0] = 1'b1;
            end
        end
        for (int e = 0; e <= 65; e++) begin
            @(posedge clk); #1;
            check_edge(0, 24'h005678, e, 1'b1);
        end
`endif

        for (int k = 0; k < 6; k++) begin
            s = int'($urandom_range(0, 2));
            w = 24'($urandom) & wmask(s);
            run_xfer(s, w, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
